multichannel_amplitude_detector: RTL and testbench



---
 rtl/amplitude_detector_pkg.sv | 23 ++
 rtl/amplitude_channel_tracker.sv | 106 ++++++++++
 rtl/multichannel_amplitude_detector.sv | 170 +++++++++++++++++
 tb/tb_multichannel_amplitude_detector.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/amplitude_detector_pkg.sv
// Shared definitions for the multichannel amplitude detector.
//   - IAGC status codes that hold the detector idle (RESET, INIT)
//   - FSM state encoding
//   - tracking mode constants (absolute peak / peak-to-peak)
// Optional feature macro: AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN (affects users of MODE_*).
package amplitude_detector_pkg;

  localparam int unsigned IAGC_CODE_W = 4;

  localparam logic [IAGC_CODE_W-1:0] IAGC_RESET = 4'b0000;
  localparam logic [IAGC_CODE_W-1:0] IAGC_INIT  = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_LATCH  = 2'd2,
    ST_UPDATE = 2'd3
  } state_e;

  localparam logic MODE_ABS = 1'b0;
  localparam logic MODE_P2P = 1'b1;

endpackage

// File: rtl/amplitude_channel_tracker.sv
// One channel's peak tracker and amplitude result.
// Ports:
//   i_clock, i_reset     clock, async active-high reset
//   i_clear              synchronous clear of the trackers (priority over i_sample)
//   i_sample             fold i_data into the trackers this cycle
//   i_mode               active tracking mode (AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN only)
//   i_clear_mode         mode the trackers are being cleared for (same macro)
//   i_data               signed two's-complement channel sample
//   o_amplitude_c        combinational amplitude of the current trackers
// Macro AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN adds the min tracker and the p2p result.
module amplitude_channel_tracker
  import amplitude_detector_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_sample,
`ifdef AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN
  input  logic              i_mode,
  input  logic              i_clear_mode,
`endif
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_amplitude_c
);

  localparam logic [DATA_W-1:0] NEG_FULL = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] POS_FULL = {1'b0, {(DATA_W-1){1'b1}}};

  logic [DATA_W-1:0] abs_c;
  logic [DATA_W-1:0] peak_q, peak_d;

  // |x| with the most negative code saturated to the largest positive one
  always_comb begin
    if (i_data == NEG_FULL) begin
      abs_c = POS_FULL;
    end else if (i_data[DATA_W-1]) begin
      abs_c = -i_data;
    end else begin
      abs_c = i_data;
    end
  end

`ifdef AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W:0]   span_c;

  // peak_q is max|x| in absolute mode, signed max in p2p mode
  always_comb begin
    peak_d = peak_q;
    min_d  = min_q;
    if (i_clear) begin
      if (i_clear_mode == MODE_P2P) begin
        peak_d = NEG_FULL;
        min_d  = POS_FULL;
      end else begin
        peak_d = '0;
        min_d  = '0;
      end
    end else if (i_sample) begin
      if (i_mode == MODE_P2P) begin
        if ($signed(i_data) > $signed(peak_q)) peak_d = i_data;
        if ($signed(i_data) < $signed(min_q))  min_d  = i_data;
      end else if (abs_c > peak_q) begin
        peak_d = abs_c;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      peak_q <= '0;
      min_q  <= '0;
    end else begin
      peak_q <= peak_d;
      min_q  <= min_d;
    end
  end

  // One extra bit so max-min never wraps; halving brings it back into DATA_W
  assign span_c = {peak_q[DATA_W-1], peak_q} - {min_q[DATA_W-1], min_q};

  always_comb begin
    o_amplitude_c = peak_q;
    if (i_mode == MODE_P2P) o_amplitude_c = DATA_W'(span_c >> 1);
  end
`else
  always_comb begin
    peak_d = peak_q;
    if (i_clear) begin
      peak_d = '0;
    end else if (i_sample && (abs_c > peak_q)) begin
      peak_d = abs_c;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) peak_q <= '0;
    else         peak_q <= peak_d;
  end

  assign o_amplitude_c = peak_q;
`endif

endmodule

// File: rtl/multichannel_amplitude_detector.sv
// Windowed peak-amplitude detector for NUM_CHANNELS packed signed channels.
// Ports:
//   i_clock, i_reset   clock, async active-high reset
//   i_sample           sample strobe qualifying i_data
//   i_iagcStatus       IAGC state; RESET/INIT force the detector idle
//   i_windowLength     accepted samples per window (0 behaves as 1)
//   i_data             packed channel samples, channel k at [k*CHANNEL_DATA_SIZE +: CHANNEL_DATA_SIZE]
//   i_mode             0 absolute peak, 1 peak-to-peak/2 (AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN only)
//   o_amplitudes       packed per-channel amplitudes of the last window
//   o_update           one-cycle pulse when o_amplitudes has been refreshed
//   o_overrun          sticky: strobe arrived during LATCH/UPDATE and was dropped
// Macro AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN enables i_mode and the peak-to-peak trackers.
module multichannel_amplitude_detector
  import amplitude_detector_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS      = 2,
  parameter int unsigned CHANNEL_DATA_SIZE = 16,
  parameter int unsigned IAGC_STATUS_SIZE  = 4,
  parameter int unsigned WINDOW_SIZE_BITS  = 12
) (
  input  logic                                      i_clock,
  input  logic                                      i_reset,
  input  logic                                      i_sample,
  input  logic [IAGC_STATUS_SIZE-1:0]               i_iagcStatus,
  input  logic [WINDOW_SIZE_BITS-1:0]               i_windowLength,
  input  logic [NUM_CHANNELS*CHANNEL_DATA_SIZE-1:0] i_data,
`ifdef AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN
  input  logic                                      i_mode,
`endif
  output logic [NUM_CHANNELS*CHANNEL_DATA_SIZE-1:0] o_amplitudes,
  output logic                                      o_update,
  output logic                                      o_overrun
);

  localparam int unsigned BUS_W = NUM_CHANNELS * CHANNEL_DATA_SIZE;
  localparam int unsigned CNT_W = WINDOW_SIZE_BITS;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  win_q, win_d;
  logic [BUS_W-1:0]  amp_q, amp_d;
  logic              overrun_q, overrun_d;
  logic              update_q, update_d;

  logic              hold_c;
  logic              trk_clear_c;
  logic              trk_sample_c;
  logic [CNT_W-1:0]  win_len_c;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic [BUS_W-1:0]  trk_amp_c;

`ifdef AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN
  logic mode_q, mode_d;
`endif

  assign hold_c    = (i_iagcStatus == IAGC_STATUS_SIZE'(IAGC_RESET)) ||
                     (i_iagcStatus == IAGC_STATUS_SIZE'(IAGC_INIT));
  assign win_len_c = (win_q == '0) ? CNT_W'(1) : win_q;
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  // Next-state, counter, capture and output-register logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    win_d        = win_q;
    amp_d        = amp_q;
    overrun_d    = overrun_q;
    update_d     = 1'b0;
    trk_clear_c  = 1'b0;
    trk_sample_c = 1'b0;
`ifdef AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN
    mode_d       = mode_q;
`endif

    if (hold_c) begin
      // Abort: partial window discarded, no update pulse
      state_d     = ST_IDLE;
      cnt_d       = '0;
      amp_d       = '0;
      overrun_d   = 1'b0;
      trk_clear_c = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          trk_clear_c = 1'b1;
          cnt_d       = '0;
          win_d       = i_windowLength;
`ifdef AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN
          mode_d      = i_mode;
`endif
          state_d     = ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (i_sample) begin
            trk_sample_c = 1'b1;
            cnt_d        = cnt_inc_c;
            if (cnt_inc_c == win_len_c) state_d = ST_LATCH;
          end
        end
        ST_LATCH: begin
          amp_d    = trk_amp_c;
          update_d = 1'b1;
          state_d  = ST_UPDATE;
          if (i_sample) overrun_d = 1'b1;
        end
        ST_UPDATE: begin
          trk_clear_c = 1'b1;
          cnt_d       = '0;
          win_d       = i_windowLength;
`ifdef AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN
          mode_d      = i_mode;
`endif
          state_d     = ST_SAMPLE;
          if (i_sample) overrun_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      win_q     <= '0;
      amp_q     <= '0;
      overrun_q <= 1'b0;
      update_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      amp_q     <= amp_d;
      overrun_q <= overrun_d;
      update_q  <= update_d;
    end
  end

`ifdef AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) mode_q <= MODE_ABS;
    else         mode_q <= mode_d;
  end
`endif

  // Per-channel trackers; clear values follow i_mode since it is what the next window captures
  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    amplitude_channel_tracker #(
      .DATA_W(CHANNEL_DATA_SIZE)
    ) u_tracker (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_clear       (trk_clear_c),
      .i_sample      (trk_sample_c),
`ifdef AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN
      .i_mode        (mode_q),
      .i_clear_mode  (i_mode),
`endif
      .i_data        (i_data[k*CHANNEL_DATA_SIZE +: CHANNEL_DATA_SIZE]),
      .o_amplitude_c (trk_amp_c[k*CHANNEL_DATA_SIZE +: CHANNEL_DATA_SIZE])
    );
  end

  assign o_amplitudes = amp_q;
  assign o_update     = update_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_multichannel_amplitude_detector.sv
// Directed bench for multichannel_amplitude_detector (2 channels x 16 bits).
// Expected window results are queued when the closing strobe is driven and
// popped when o_update is due. Peak-to-peak steps are built only when
// AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN is defined.
module tb_multichannel_amplitude_detector;

  localparam int unsigned NCH = 2;
  localparam int unsigned CW  = 16;
  localparam int unsigned SW  = 4;
  localparam int unsigned WW  = 12;
  localparam int unsigned DW  = NCH * CW;

  localparam logic [SW-1:0] ST_INIT_C = 4'b0001;
  localparam logic [SW-1:0] ST_RUN_C  = 4'b0010;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_sample;
  logic [SW-1:0] i_iagcStatus;
  logic [WW-1:0] i_windowLength;
  logic [DW-1:0] i_data;
`ifdef AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN
  logic          i_mode;
`endif
  logic [DW-1:0] o_amplitudes;
  logic          o_update;
  logic          o_overrun;

  int n_checks = 0;
  int n_errors = 0;
  int n_win    = 0;
  int upd_cnt  = 0;

  logic [DW-1:0] sb_q[$];

  multichannel_amplitude_detector #(
    .NUM_CHANNELS     (NCH),
    .CHANNEL_DATA_SIZE(CW),
    .IAGC_STATUS_SIZE (SW),
    .WINDOW_SIZE_BITS (WW)
  ) dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_sample       (i_sample),
    .i_iagcStatus   (i_iagcStatus),
    .i_windowLength (i_windowLength),
    .i_data         (i_data),
`ifdef AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN
    .i_mode         (i_mode),
`endif
    .o_amplitudes   (o_amplitudes),
    .o_update       (o_update),
    .o_overrun      (o_overrun)
  );

  always #5 clk = ~clk;

  // Counts update pulses; each pulse is one cycle so it is seen at exactly one edge
  always @(posedge clk) begin
    if (o_update === 1'b1) upd_cnt <= upd_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [DW-1:0] pack(input int c0, input int c1);
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    a = CW'(c0);
    b = CW'(c1);
    return {b, a};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one accepted strobe; returns at the negedge after the accepting edge
  task automatic strobe(input logic [DW-1:0] d);
    i_data   = d;
    i_sample = 1'b1;
    @(negedge clk);
    i_sample = 1'b0;
  endtask

  // Called in the LATCH cycle right after a window's last strobe
  task automatic window_done(input string tag, input bit in_latch, input bit in_update,
                             input logic [DW-1:0] junk);
    logic [DW-1:0] exp;
    n_win++;
    i_data   = junk;
    i_sample = in_latch;
    chk({tag, "_latch_no_upd"}, DW'(o_update), DW'(0));
    @(negedge clk);
    i_sample = in_update;
    chk({tag, "_upd_high"}, DW'(o_update), DW'(1));
    n_checks++;
    assert (sb_q.size() != 0) else begin
      n_errors++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
    end
    if (sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      chk({tag, "_amp"}, o_amplitudes, exp);
    end
    @(negedge clk);
    i_sample = 1'b0;
    chk({tag, "_upd_low"}, DW'(o_update), DW'(0));
  endtask

  initial begin
    int u0;
    i_reset        = 1'b1;
    i_sample       = 1'b0;
    i_iagcStatus   = ST_INIT_C;
    i_windowLength = WW'(4);
    i_data         = '0;
`ifdef AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN
    i_mode         = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_amp", o_amplitudes, '0);
    chk("rst_upd", DW'(o_update), DW'(0));
    chk("rst_ovr", DW'(o_overrun), DW'(0));

    i_reset = 1'b0;
    @(negedge clk);
    i_iagcStatus = ST_RUN_C;
    @(negedge clk);

    // Window 4, basic absolute peaks
    strobe(pack(3, 100));
    strobe(pack(-7, -100));
    strobe(pack(5, 0));
    sb_q.push_back(pack(7, 100));
    strobe(pack(2, 1));
    window_done("abs_basic", 1'b0, 1'b0, '0);
    chk("abs_basic_ovr", DW'(o_overrun), DW'(0));

    // Most negative code saturates; strobe during UPDATE is dropped
    strobe(pack(-32768, 5));
    strobe(pack(0, -32767));
    strobe(pack(1, 0));
    sb_q.push_back(pack(32767, 32767));
    strobe(pack(2, 3));
    window_done("abs_sat", 1'b0, 1'b1, pack(1000, 1000));
    chk("upd_overrun", DW'(o_overrun), DW'(1));

    strobe(pack(1, 2));
    strobe(pack(1, -2));
    strobe(pack(-1, 2));
    sb_q.push_back(pack(1, 2));
    strobe(pack(1, 2));
    window_done("after_drop", 1'b0, 1'b0, '0);
    chk("ovr_sticky", DW'(o_overrun), DW'(1));

    // INIT after 2 of 4 samples aborts the window
    strobe(pack(50, 50));
    strobe(pack(60, 60));
    u0 = upd_cnt;
    i_iagcStatus = ST_INIT_C;
    @(negedge clk);
    chk("init_amp", o_amplitudes, '0);
    chk("init_ovr", DW'(o_overrun), DW'(0));
    chk("init_upd", DW'(o_update), DW'(0));
    i_iagcStatus = ST_RUN_C;
    @(negedge clk);
    chk("init_no_pulse", DW'(upd_cnt), DW'(u0));

    // Full count restarts; mid-window length change has no effect
    strobe(pack(1, -1));
    i_windowLength = WW'(2);
    strobe(pack(2, -2));
    strobe(pack(3, -3));
    sb_q.push_back(pack(4, 4));
    strobe(pack(4, -4));
    window_done("restart", 1'b0, 1'b0, '0);

    // Length 2 captured at the previous UPDATE
    strobe(pack(7, 7));
    i_windowLength = WW'(0);
    sb_q.push_back(pack(8, 8));
    strobe(pack(-8, 8));
    window_done("win2", 1'b0, 1'b0, '0);

    // Length 0 acts as 1; strobe during LATCH sets overrun
    sb_q.push_back(pack(9, 9));
    strobe(pack(9, -9));
    window_done("win0_a", 1'b0, 1'b0, '0);
    i_windowLength = WW'(4);
    sb_q.push_back(pack(1, 0));
    strobe(pack(-1, 0));
    window_done("win0_b", 1'b1, 1'b0, pack(500, 500));
    chk("latch_overrun", DW'(o_overrun), DW'(1));

    // Async reset mid-window, no clock edge needed
    strobe(pack(100, 100));
    #2 i_reset = 1'b1;
    #1;
    chk("areset_amp", o_amplitudes, '0);
    chk("areset_upd", DW'(o_update), DW'(0));
    chk("areset_ovr", DW'(o_overrun), DW'(0));
    @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    strobe(pack(3, 1));
    strobe(pack(-3, 2));
    strobe(pack(0, 0));
    sb_q.push_back(pack(3, 2));
    strobe(pack(1, -2));
    window_done("post_reset", 1'b0, 1'b0, '0);

`ifdef AMPLITUDE_DETECTOR_PEAK_TO_PEAK_EN
    // Peak-to-peak, window 3
    i_iagcStatus   = ST_INIT_C;
    i_mode         = 1'b1;
    i_windowLength = WW'(3);
    @(negedge clk);
    i_iagcStatus = ST_RUN_C;
    @(negedge clk);
    strobe(pack(-10, 0));
    strobe(pack(20, 0));
    sb_q.push_back(pack(15, 0));
    strobe(pack(4, 0));
    window_done("p2p_basic", 1'b0, 1'b0, '0);

    strobe(pack(5, -5));
    strobe(pack(5, -5));
    sb_q.push_back(pack(0, 0));
    strobe(pack(5, -5));
    window_done("p2p_const", 1'b0, 1'b0, '0);

    strobe(pack(-32768, 1));
    strobe(pack(32767, 1));
    sb_q.push_back(pack(32767, 0));
    strobe(pack(0, 1));
    window_done("p2p_full", 1'b0, 1'b0, '0);
`endif

    @(negedge clk);
    chk("update_count", DW'(upd_cnt), DW'(n_win));
    chk("sb_drained", DW'(sb_q.size()), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
